// File: rtl/blk_interleaver.sv
// rtl/blk_interleaver.sv - ROWS x COLS ping-pong block interleaver; optional deinterleave mode under INTERL_DEINT_EN
module blk_interleaver #(
    parameter int    DATA_W    = 1,
    parameter int    ROWS      = 64,
    parameter int    COLS      = 256,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef INTERL_DEINT_EN
    input  logic              deint_mode,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              ovf_err
);

    localparam int N      = ROWS * COLS;
    localparam int ADDR_W = $clog2(N);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    if (ROWS < 2 || COLS < 2) begin : g_bad_dims
        $error("blk_interleaver: ROWS and COLS must each be >= 2");
    end

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_st_t;

    // addr is the live RAM offset; inner/outer only matter for the strided walk
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RW-1:0]     inner;
        logic [CW-1:0]     outer;
    } agen_t;

    // Linear walk adds 1; strided walk adds COLS and restarts at the next column after ROWS steps
    function automatic agen_t agen_next(input agen_t cur, input logic strided);
        agen_t nxt;
        nxt = cur;
        if (!strided) begin
            nxt.addr = cur.addr + ADDR_W'(1);
        end else if (cur.inner == RW'(ROWS - 1)) begin
            nxt.inner = '0;
            nxt.outer = cur.outer + CW'(1);
            nxt.addr  = ADDR_W'(cur.outer) + ADDR_W'(1);
        end else begin
            nxt.inner = cur.inner + RW'(1);
            nxt.addr  = cur.addr + COLS_A;
        end
        return nxt;
    endfunction

    bank_st_t          bank_st [2];
    logic              run;
    logic              wr_bank, rd_bank, out_bank, rd_busy;
    agen_t             wr_gen, rd_gen;
    logic              ram_valid, ram_last;
    logic [DATA_W-1:0] ram_q;
    logic              sp_valid, sp_last;
    logic [DATA_W-1:0] sp_data;
    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    logic       wr_fire, wr_last, wr_mode;
    logic       rd_fire, rd_last, rd_avail, rd_room, rd_strided;
    logic       pop, pop_last;
    logic [1:0] occ;

`ifdef INTERL_DEINT_EN
    logic bank_mode [2];

    // A block's order is fixed by deint_mode on its first symbol
    assign wr_mode    = (bank_st[wr_bank] == B_EMPTY) ? deint_mode : bank_mode[wr_bank];
    assign rd_strided = ~bank_mode[rd_bank];

    // Latch the per-bank mode when the bank starts filling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_mode[0] <= 1'b0;
            bank_mode[1] <= 1'b0;
        end else if (clr) begin
            bank_mode[0] <= 1'b0;
            bank_mode[1] <= 1'b0;
        end else if (wr_fire && bank_st[wr_bank] == B_EMPTY) begin
            bank_mode[wr_bank] <= wr_mode;
        end
    end
`else
    assign wr_mode    = 1'b0;
    assign rd_strided = 1'b1;
`endif

    assign in_ready = run && (bank_st[wr_bank] == B_EMPTY || bank_st[wr_bank] == B_FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (wr_gen.addr == LAST_A);

    assign pop      = out_valid && out_ready;
    assign pop_last = pop && out_last;

    // Symbols in flight (head, spare, RAM stage); issue only if the skid can absorb the result
    assign occ      = 2'(out_valid) + 2'(sp_valid) + 2'(ram_valid);
    assign rd_room  = occ <= (2'd1 + 2'(pop));
    assign rd_avail = rd_busy || (bank_st[rd_bank] == B_FULL);
    assign rd_fire  = rd_avail && rd_room;
    assign rd_last  = rd_fire && (rd_gen.addr == LAST_A);

    // Ping-pong RAM: write port for the filling bank, registered read for the draining bank
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_gen.addr}] <= in_data;
        if (rd_fire) ram_q <= mem[{rd_bank, rd_gen.addr}];
    end

    // Bank lifecycle and bank pointers; a bank is released only when its last symbol leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            out_bank   <= 1'b0;
            rd_busy    <= 1'b0;
        end else if (clr) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            out_bank   <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    bank_st[wr_bank] <= B_FULL;
                    wr_bank          <= ~wr_bank;
                end else if (bank_st[wr_bank] == B_EMPTY) begin
                    bank_st[wr_bank] <= B_FILLING;
                end
            end
            if (rd_fire) begin
                if (bank_st[rd_bank] == B_FULL) bank_st[rd_bank] <= B_DRAINING;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                    rd_busy <= 1'b0;
                end else begin
                    rd_busy <= 1'b1;
                end
            end
            if (pop_last) begin
                bank_st[out_bank] <= B_EMPTY;
                out_bank          <= ~out_bank;
            end
        end
    end

    // Write (row-major) and read (column-major) address generators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_gen <= '0;
            rd_gen <= '0;
        end else if (clr) begin
            wr_gen <= '0;
            rd_gen <= '0;
        end else begin
            if (wr_fire) wr_gen <= wr_last ? '0 : agen_next(wr_gen, wr_mode);
            if (rd_fire) rd_gen <= rd_last ? '0 : agen_next(rd_gen, rd_strided);
        end
    end

    // RAM output stage feeding a two-entry skid (registered head plus one spare)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_valid <= 1'b0;
            ram_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            sp_valid  <= 1'b0;
            sp_last   <= 1'b0;
            sp_data   <= '0;
        end else if (clr) begin
            ram_valid <= 1'b0;
            ram_last  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            sp_valid  <= 1'b0;
            sp_last   <= 1'b0;
            sp_data   <= '0;
        end else begin
            ram_valid <= rd_fire;
            ram_last  <= rd_last;
            if (!out_valid || out_ready) begin
                if (sp_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= sp_data;
                    out_last  <= sp_last;
                    sp_valid  <= ram_valid;
                    sp_data   <= ram_q;
                    sp_last   <= ram_last;
                end else begin
                    out_valid <= ram_valid;
                    out_last  <= ram_valid && ram_last;
                    if (ram_valid) out_data <= ram_q;
                end
            end else if (ram_valid) begin
                sp_valid <= 1'b1;
                sp_data  <= ram_q;
                sp_last  <= ram_last;
            end
        end
    end

    // Run flag gates in_ready after reset; overflow is sticky until reset or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            ovf_err <= 1'b0;
        end else if (clr) begin
            run     <= 1'b1;
            ovf_err <= 1'b0;
        end else begin
            run <= 1'b1;
            if (in_valid && !in_ready && run) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_blk_interleaver.sv
// tb/tb_blk_interleaver.sv - randomized self-checking bench for blk_interleaver (4x3, 8-bit)
module tb_blk_interleaver;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 3;
    localparam int N  = R * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          ovf_err;
    logic          deint_mode;

    always #5 clk = ~clk;

    blk_interleaver #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef INTERL_DEINT_EN
        .deint_mode(deint_mode),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .ovf_err(ovf_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: collect N symbols, then emit the permuted block
    logic [DW-1:0] blk[$];
    logic [DW:0]   exp_q[$];
    logic          blk_mode;
    logic          exp_ovf;

    task automatic model_push(input logic [DW-1:0] d, input logic mode);
        int src;
        if (blk.size() == 0) blk_mode = mode;
        blk.push_back(d);
        if (blk.size() == N) begin
            for (int k = 0; k < N; k++) begin
                if (blk_mode) src = (k % C) * R + k / C;
                else          src = (k % R) * C + k / R;
                exp_q.push_back({k == N - 1, blk[src]});
            end
            blk.delete();
        end
    endtask

    logic          iv, ordy, dm, last_acc;
    logic [DW-1:0] id;
    logic          hold_pend, hold_last;
    logic [DW-1:0] hold_data;
    int  cyc = 0, ov_first = -1, last_in_cyc = 0, out_idx = 0, blk_first_cyc = 0;
    int  n_freed = 0;
    bit  contig = 0, watch_free = 0, free_next = 0;

    task automatic flush();
        blk.delete();
        exp_q.delete();
        exp_ovf   = 1'b0;
        hold_pend = 1'b0;
        out_idx   = 0;
        free_next = 0;
    endtask

    // One cycle: drive at negedge, check outputs, predict the handshakes of the next edge
    task automatic step();
        logic [DW:0] e;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; deint_mode = dm;
        check("ovf_err", ovf_err, exp_ovf);
        if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
            check("hold_last", out_last, hold_last);
        end
        if (free_next) begin
            check("in_ready_after_free", in_ready, 1);
            free_next = 0;
        end
        if (out_valid && ov_first < 0) ov_first = cyc;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[DW-1:0]);
                check("out_last", out_last, e[DW]);
            end
            if (out_idx == 0) blk_first_cyc = cyc;
            if (out_idx == N - 1) begin
                if (contig) check("block_contiguous", cyc - blk_first_cyc, N - 1);
                if (watch_free) begin
                    if (n_freed == 0) check("in_ready_before_free", in_ready, 0);
                    free_next = 1;
                    n_freed++;
                end
            end
            out_idx = (out_idx + 1) % N;
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        last_acc  = in_valid && in_ready;
        if (last_acc) begin
            model_push(in_data, dm);
            last_in_cyc = cyc;
        end else if (in_valid) begin
            exp_ovf = 1'b1;
        end
        cyc++;
    endtask

    // perm=1 feeds the interleaved order of first..first+N-1
    task automatic feed_seq(input int first, input int count, input int rdy_pct, input int budget, input bit perm);
        int got = 0;
        for (int i = 0; i < budget && got < count; i++) begin
            iv   = 1'b1;
            id   = perm ? DW'(first + (got % R) * C + (got % N) / R) : DW'(first + got);
            ordy = ($urandom_range(99) < rdy_pct);
            step();
            if (last_acc) got++;
        end
        iv = 1'b0;
        check("feed_budget", got, count);
    endtask

    task automatic drain(input int budget, input int rdy_pct);
        iv = 1'b0;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            ordy = ($urandom_range(99) < rdy_pct);
            step();
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        flush();
        check("clr_out_valid", out_valid, 0);
        check("clr_ovf", ovf_err, 0);
        check("clr_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_ovf"}, ovf_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        iv = 0; id = 0; ordy = 0; dm = 0; last_acc = 0;
        hold_pend = 0; hold_last = 0; hold_data = 0; exp_ovf = 0;
        in_valid = 0; in_data = 0; out_ready = 0; deint_mode = 0;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        check("in_ready_before_first_edge", in_ready, 0);
        @(posedge clk); #1 check("in_ready_after_first_edge", in_ready, 1);

        // Single block, latency and permutation
        contig = 1; ov_first = -1;
        feed_seq(0, N, 100, 40, 0);
        drain(40, 100);
        check("first_out_latency", ov_first - last_in_cyc, 3);

        // Three blocks with both sides held ready
        feed_seq(0, 3 * N, 100, 200, 0);
        drain(80, 100);
        do_clr();

        // Full stall: both banks fill, overflow, then release
        watch_free = 1; n_freed = 0; got = 0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            iv = 1'b1; id = DW'(100 + got); ordy = 1'b0;
            step();
            if (last_acc) got++;
        end
        check("stall_accepted", got, 2 * N);
        check("stall_in_ready", in_ready, 0);
        iv = 1'b0; ordy = 1'b0;
        step();
        check("ovf_set", ovf_err, 1);
        drain(100, 100);
        iv = 1'b0; step();
        check("banks_freed", n_freed, 2);
        watch_free = 0;

        // Random traffic with 30% downstream duty
        contig = 0; got = 0;
        for (int i = 0; i < 3000 && got < 4 * N; i++) begin
            iv   = ($urandom_range(99) < 70);
            id   = DW'($urandom);
            ordy = ($urandom_range(99) < 30);
            step();
            if (last_acc) got++;
        end
        iv = 1'b0;
        check("rand_fed", got, 4 * N);
        drain(2000, 30);

        // clr while block 1 drains and block 2 is partial
        contig = 1;
        feed_seq(100, N, 100, 40, 0);
        feed_seq(200, 5, 100, 20, 0);
        do_clr();
        feed_seq(0, N, 100, 40, 0);
        drain(60, 100);

        // Asynchronous reset pulse in the middle of a cycle
        feed_seq(50, N, 100, 40, 0);
        feed_seq(150, 5, 100, 20, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1 check("async_rst_hold_valid", out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        flush();
        check("rst_release_in_ready_low", in_ready, 0);
        @(posedge clk); #1 check("rst_release_in_ready_rise", in_ready, 1);
        feed_seq(0, N, 100, 40, 0);
        drain(60, 100);

`ifdef INTERL_DEINT_EN
        // Deinterleave an interleaved block, then a normal block
        dm = 1'b1;
        feed_seq(0, N, 100, 40, 1);
        dm = 1'b0;
        feed_seq(0, N, 100, 40, 0);
        drain(80, 100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
